// File: rtl/brt_commit_ctrl_if.sv
// ----------------------------------------------------------------------------
// brt_commit_ctrl_if
//
// Purpose:
//   Bundles the three handshakes of the branch commit controller: the ROB
//   head commit request/ack, the BRT commit request/resolution, and the
//   fetch redirect. Signal names keep the controller's point of view
//   (i_* flows into the controller, o_* flows out of it).
//
// Modports:
//   master : the commit controller (drives o_*, samples i_*)
//   slave  : the environment around it (ROB, BRT, fetch)
//
// Signals:
//   i_rob_commit_req        ROB head is a branch ready to retire
//   i_rob_commit_rob_addr   ROB address of that branch
//   o_rob_commit_ack        one-cycle retire pulse
//   o_brt_commit            commit request to BRT
//   o_brt_commit_rob_addr   latched ROB address sent to BRT
//   i_brt_commit_done       BRT resolved and released the entry
//   i_brt_commit_miss_pre   valid with done: branch was mispredicted
//   i_brt_commit_cal_target valid with done: correct next PC
//   o_redirect_v            fetch redirect valid
//   o_redirect_pc           fetch redirect PC
//   i_fetch_redirect_ready  fetch accepts the redirect
// ----------------------------------------------------------------------------
interface brt_commit_ctrl_if #(
    parameter int ROBSIZE = 8
);
    logic               i_rob_commit_req;
    logic [ROBSIZE-1:0] i_rob_commit_rob_addr;
    logic               o_rob_commit_ack;

    logic               o_brt_commit;
    logic [ROBSIZE-1:0] o_brt_commit_rob_addr;
    logic               i_brt_commit_done;
    logic               i_brt_commit_miss_pre;
    logic [31:0]        i_brt_commit_cal_target;

    logic               o_redirect_v;
    logic [31:0]        o_redirect_pc;
    logic               i_fetch_redirect_ready;

    modport master (
        input  i_rob_commit_req,
        input  i_rob_commit_rob_addr,
        output o_rob_commit_ack,
        output o_brt_commit,
        output o_brt_commit_rob_addr,
        input  i_brt_commit_done,
        input  i_brt_commit_miss_pre,
        input  i_brt_commit_cal_target,
        output o_redirect_v,
        output o_redirect_pc,
        input  i_fetch_redirect_ready
    );

    modport slave (
        output i_rob_commit_req,
        output i_rob_commit_rob_addr,
        input  o_rob_commit_ack,
        input  o_brt_commit,
        input  o_brt_commit_rob_addr,
        output i_brt_commit_done,
        output i_brt_commit_miss_pre,
        output i_brt_commit_cal_target,
        input  o_redirect_v,
        input  o_redirect_pc,
        output i_fetch_redirect_ready
    );
endinterface

// File: rtl/brt_commit_ctrl.sv
// ----------------------------------------------------------------------------
// brt_commit_ctrl
//
// Purpose:
//   Retires branch entries from the branch resolution table. A commit
//   request from the ROB head is forwarded to the BRT; a correct prediction
//   is acknowledged straight away, a misprediction first broadcasts a flush
//   for FLUSH_CYCLES cycles, then holds a fetch redirect until fetch takes
//   it, and only then acknowledges the ROB.
//
// Ports:
//   clk            clock
//   rstn           asynchronous active-low reset
//   i_ext_flush    external abort (exception/trap), returns to IDLE
//   bus            commit/BRT/redirect handshakes (master modport)
//   o_flush        flush to BRT, ROB and pipeline
//   o_busy         controller not idle
//   o_timeout_err  sticky: BRT did not resolve within TIMEOUT cycles
//   o_commit_cnt   retired branches (wraps)
//   o_mispred_cnt  mispredicted branches (wraps)
//
// All outputs are decoded from registered state only.
// ----------------------------------------------------------------------------
module brt_commit_ctrl #(
    parameter int ROBSIZE      = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 64,
    parameter int CNTW         = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_ext_flush,
    brt_commit_ctrl_if.master    bus,
    output logic                 o_flush,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    output logic [CNTW-1:0]      o_commit_cnt,
    output logic [CNTW-1:0]      o_mispred_cnt
);

    // The flush counter only needs to reach FLUSH_CYCLES-1; the wait counter
    // saturates at TIMEOUT.
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FLUSH,
        S_REDIRECT,
        S_ACK
    } state_e;

    state_e             state_q, state_d;
    logic [ROBSIZE-1:0] addr_q, addr_d;
    logic [31:0]        target_q, target_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [WCW-1:0]     wait_inc;
    logic               err_q, err_d;
    logic [CNTW-1:0]    commit_cnt_q, commit_cnt_d;
    logic [CNTW-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic               ack_o, brt_commit_o, flush_o, redirect_v_o, busy_o;

    // State and datapath registers; reset drops everything, including the
    // state-decoded outputs, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            target_q      <= '0;
            flush_cnt_q   <= '0;
            wait_q        <= '0;
            err_q         <= 1'b0;
            commit_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            target_q      <= target_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_q        <= wait_d;
            err_q         <= err_d;
            commit_cnt_q  <= commit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Next-state logic. The external abort is applied last so it overrides
    // BRT resolution and fetch acceptance arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_rob_commit_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.i_brt_commit_done) begin
                    state_d = bus.i_brt_commit_miss_pre ? S_FLUSH : S_ACK;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (bus.i_fetch_redirect_ready) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_ext_flush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next values: address/target latches, flush and wait counters,
    // sticky timeout flag and the performance counters.
    always_comb begin
        addr_d        = addr_q;
        target_d      = target_q;
        flush_cnt_d   = flush_cnt_q;
        wait_d        = wait_q;
        err_d         = err_q;
        commit_cnt_d  = commit_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        wait_inc      = wait_q + 1'b1;

        if (state_q == S_IDLE && bus.i_rob_commit_req && !i_ext_flush) begin
            addr_d = bus.i_rob_commit_rob_addr;
        end

        if (state_q == S_REQ && bus.i_brt_commit_done && !i_ext_flush) begin
            target_d = bus.i_brt_commit_cal_target;
            if (bus.i_brt_commit_miss_pre) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end

        // Wait counter saturates at the limit so the flag keeps its meaning
        // however long the BRT stalls.
        if (TIMEOUT > 0 && state_q == S_REQ && !bus.i_brt_commit_done
                && wait_q != WAIT_LIMIT) begin
            wait_d = wait_inc;
            if (wait_inc == WAIT_LIMIT) begin
                err_d = 1'b1;
            end
        end
        if (state_d != S_REQ) begin
            wait_d = '0;
        end

        if (state_q == S_FLUSH) begin
            flush_cnt_d = (flush_cnt_q == FLUSH_LAST) ? '0 : flush_cnt_q + 1'b1;
        end
        if (i_ext_flush) begin
            flush_cnt_d = '0;
        end

        // Counted on entry to ACK so the count moves together with the ack.
        if (state_d == S_ACK && state_q != S_ACK) begin
            commit_cnt_d = commit_cnt_q + 1'b1;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        ack_o        = 1'b0;
        brt_commit_o = 1'b0;
        flush_o      = 1'b0;
        redirect_v_o = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_REQ:      brt_commit_o = 1'b1;
            S_FLUSH:    flush_o      = 1'b1;
            S_REDIRECT: redirect_v_o = 1'b1;
            S_ACK:      ack_o        = 1'b1;
            default:    ;
        endcase
    end

    assign bus.o_rob_commit_ack      = ack_o;
    assign bus.o_brt_commit          = brt_commit_o;
    assign bus.o_brt_commit_rob_addr = addr_q;
    assign bus.o_redirect_v          = redirect_v_o;
    assign bus.o_redirect_pc         = target_q;

    assign o_flush       = flush_o;
    assign o_busy        = busy_o;
    assign o_timeout_err = err_q;
    assign o_commit_cnt  = commit_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_brt_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_brt_commit_ctrl
//
// Purpose:
//   Self-checking bench for brt_commit_ctrl. Every accepted request pushes
//   its ROB address to a queue; a monitor pops it when the ack appears and
//   checks the retired address. Each scenario task checks its own timing
//   and counter values inline.
// ----------------------------------------------------------------------------
module tb_brt_commit_ctrl;

    localparam int ROBSIZE = 8;
    localparam int CNTW    = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            ext_flush;
    logic            flush;
    logic            busy;
    logic            timeoutErr;
    logic [CNTW-1:0] commitCnt;
    logic [CNTW-1:0] mispredCnt;

    int compared   = 0;
    int mismatched = 0;
    int expCommit  = 0;
    int expMispred = 0;
    logic [ROBSIZE-1:0] expAddrQ[$];

    brt_commit_ctrl_if #(.ROBSIZE(ROBSIZE)) bus ();

    brt_commit_ctrl #(
        .ROBSIZE(ROBSIZE),
        .FLUSH_CYCLES(2),
        .TIMEOUT(64),
        .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_ext_flush(ext_flush),
        .bus(bus),
        .o_flush(flush),
        .o_busy(busy),
        .o_timeout_err(timeoutErr),
        .o_commit_cnt(commitCnt),
        .o_mispred_cnt(mispredCnt)
    );

    // Free-running clock; inputs change and outputs are sampled on the
    // falling edge so nothing races the rising edge.
    always #5 clk = ~clk;

    // Scoreboard side: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.o_rob_commit_ack === 1'b1) begin
            compared++;
            if (expAddrQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_ack: got ack for addr %0d, expected no ack",
                         bus.o_brt_commit_rob_addr);
            end else begin
                logic [ROBSIZE-1:0] expAddr;
                expAddr = expAddrQ.pop_front();
                if (bus.o_brt_commit_rob_addr !== expAddr) begin
                    mismatched++;
                    $display("[TB] FAIL ack_addr: got %0d expected %0d",
                             bus.o_brt_commit_rob_addr, expAddr);
                end
            end
        end
    end

    // Reset with all inputs quiet, then confirm every output is zero.
    task automatic test_reset();
        rstn      = 1'b0;
        ext_flush = 1'b0;
        bus.i_rob_commit_req        = 1'b0;
        bus.i_rob_commit_rob_addr   = '0;
        bus.i_brt_commit_done       = 1'b0;
        bus.i_brt_commit_miss_pre   = 1'b0;
        bus.i_brt_commit_cal_target = '0;
        bus.i_fetch_redirect_ready  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.o_rob_commit_ack, bus.o_brt_commit, bus.o_redirect_v, flush, busy, timeoutErr} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {bus.o_rob_commit_ack, bus.o_brt_commit, bus.o_redirect_v, flush, busy, timeoutErr});
        end
        compared++;
        if (commitCnt !== '0 || mispredCnt !== '0 || bus.o_redirect_pc !== '0 || bus.o_brt_commit_rob_addr !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got cnt %0d/%0d pc %h addr %0d expected all 0",
                     commitCnt, mispredCnt, bus.o_redirect_pc, bus.o_brt_commit_rob_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    // Correct prediction resolved in the first REQ cycle.
    task automatic test_correct();
        int ackCycle = -1;
        int brtCycles = 0;
        logic flushSeen = 1'b0;
        @(negedge clk);
        bus.i_rob_commit_req        = 1'b1;
        bus.i_rob_commit_rob_addr   = 8'd5;
        bus.i_brt_commit_done       = 1'b1;
        bus.i_brt_commit_miss_pre   = 1'b0;
        bus.i_brt_commit_cal_target = 32'h0000_2000;
        expAddrQ.push_back(8'd5);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.o_brt_commit === 1'b1) begin
                brtCycles++;
                compared++;
                if (bus.o_brt_commit_rob_addr !== 8'd5) begin
                    mismatched++;
                    $display("[TB] FAIL correct_brt_addr: got %0d expected 5", bus.o_brt_commit_rob_addr);
                end
            end
            if (flush === 1'b1) flushSeen = 1'b1;
            if (bus.o_rob_commit_ack === 1'b1) begin
                if (ackCycle < 0) ackCycle = c;
                bus.i_rob_commit_req  = 1'b0;
                bus.i_brt_commit_done = 1'b0;
            end
        end
        expCommit++;
        compared++;
        if (brtCycles != 1) begin
            mismatched++;
            $display("[TB] FAIL correct_brt_cycles: got %0d expected 1", brtCycles);
        end
        compared++;
        if (ackCycle != 2) begin
            mismatched++;
            $display("[TB] FAIL correct_ack_latency: got %0d expected 2", ackCycle);
        end
        compared++;
        if (commitCnt !== CNTW'(expCommit)) begin
            mismatched++;
            $display("[TB] FAIL correct_commit_cnt: got %0d expected %0d", commitCnt, expCommit);
        end
        compared++;
        if (flushSeen !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL correct_idle: got flush_seen %b busy %b expected 0 0", flushSeen, busy);
        end
    endtask

    // Misprediction; fetch accepts in the third REDIRECT cycle.
    task automatic test_mispredict();
        int ackCycle = -1;
        int flushCycles = 0;
        int rdCycles = 0;
        int pcBad = 0;
        @(negedge clk);
        bus.i_rob_commit_req        = 1'b1;
        bus.i_rob_commit_rob_addr   = 8'd9;
        bus.i_brt_commit_done       = 1'b1;
        bus.i_brt_commit_miss_pre   = 1'b1;
        bus.i_brt_commit_cal_target = 32'h0000_1000;
        bus.i_fetch_redirect_ready  = 1'b0;
        expAddrQ.push_back(8'd9);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (flush === 1'b1) begin
                flushCycles++;
                if (bus.o_redirect_pc !== 32'h0000_1000) pcBad++;
            end
            if (bus.o_redirect_v === 1'b1) begin
                rdCycles++;
                if (bus.o_redirect_pc !== 32'h0000_1000) pcBad++;
                if (rdCycles == 3) bus.i_fetch_redirect_ready = 1'b1;
            end
            if (bus.o_rob_commit_ack === 1'b1) begin
                if (ackCycle < 0) ackCycle = c;
                bus.i_rob_commit_req       = 1'b0;
                bus.i_brt_commit_done      = 1'b0;
                bus.i_brt_commit_miss_pre  = 1'b0;
                bus.i_fetch_redirect_ready = 1'b0;
            end
        end
        expCommit++;
        expMispred++;
        compared++;
        if (flushCycles != 2) begin
            mismatched++;
            $display("[TB] FAIL mispred_flush_cycles: got %0d expected 2", flushCycles);
        end
        compared++;
        if (rdCycles != 3) begin
            mismatched++;
            $display("[TB] FAIL mispred_redirect_cycles: got %0d expected 3", rdCycles);
        end
        compared++;
        if (pcBad != 0) begin
            mismatched++;
            $display("[TB] FAIL mispred_redirect_pc: got %0d bad cycles expected 0", pcBad);
        end
        compared++;
        if (ackCycle != 7) begin
            mismatched++;
            $display("[TB] FAIL mispred_ack_latency: got %0d expected 7", ackCycle);
        end
        compared++;
        if (mispredCnt !== CNTW'(expMispred) || commitCnt !== CNTW'(expCommit)) begin
            mismatched++;
            $display("[TB] FAIL mispred_counters: got %0d/%0d expected %0d/%0d",
                     mispredCnt, commitCnt, expMispred, expCommit);
        end
    endtask

    // BRT stalls for 70 REQ cycles; the error flag must rise after 64 and stick.
    task automatic test_timeout();
        int ackCycle = -1;
        int firstErr = -1;
        @(negedge clk);
        compared++;
        if (timeoutErr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_initial: got %b expected 0", timeoutErr);
        end
        bus.i_rob_commit_req      = 1'b1;
        bus.i_rob_commit_rob_addr = 8'h21;
        bus.i_brt_commit_done     = 1'b0;
        bus.i_brt_commit_miss_pre = 1'b0;
        expAddrQ.push_back(8'h21);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (timeoutErr === 1'b1 && firstErr < 0) firstErr = c;
            if (c == 70) bus.i_brt_commit_done = 1'b1;
            if (bus.o_rob_commit_ack === 1'b1) begin
                if (ackCycle < 0) ackCycle = c;
                bus.i_rob_commit_req  = 1'b0;
                bus.i_brt_commit_done = 1'b0;
            end
        end
        expCommit++;
        compared++;
        if (firstErr != 65) begin
            mismatched++;
            $display("[TB] FAIL timeout_rise_cycle: got %0d expected 65", firstErr);
        end
        compared++;
        if (ackCycle != 71) begin
            mismatched++;
            $display("[TB] FAIL timeout_ack_cycle: got %0d expected 71", ackCycle);
        end
        compared++;
        if (timeoutErr !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_sticky: got err %b busy %b expected 1 0", timeoutErr, busy);
        end
    endtask

    // External abort in FLUSH cycle 1, then in REDIRECT together with ready.
    task automatic test_ext_flush();
        logic ackSeen = 1'b0;
        int flushCycles = 0;
        int rdCycles = 0;
        @(negedge clk);
        bus.i_rob_commit_req        = 1'b1;
        bus.i_rob_commit_rob_addr   = 8'h11;
        bus.i_brt_commit_done       = 1'b1;
        bus.i_brt_commit_miss_pre   = 1'b1;
        bus.i_brt_commit_cal_target = 32'h0000_3000;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.o_rob_commit_ack === 1'b1) ackSeen = 1'b1;
            if (c == 2) begin
                compared++;
                if (flush !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL extf_in_flush: got %b expected 1", flush);
                end
                ext_flush = 1'b1;
            end
            if (c == 3) begin
                compared++;
                if (busy !== 1'b0 || flush !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL extf_flush_abort: got busy %b flush %b expected 0 0", busy, flush);
                end
                ext_flush = 1'b0;
                bus.i_rob_commit_req      = 1'b0;
                bus.i_brt_commit_done     = 1'b0;
                bus.i_brt_commit_miss_pre = 1'b0;
            end
        end
        expMispred++;

        @(negedge clk);
        bus.i_rob_commit_req        = 1'b1;
        bus.i_rob_commit_rob_addr   = 8'h12;
        bus.i_brt_commit_done       = 1'b1;
        bus.i_brt_commit_miss_pre   = 1'b1;
        bus.i_brt_commit_cal_target = 32'h0000_4000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.o_rob_commit_ack === 1'b1) ackSeen = 1'b1;
            if (flush === 1'b1) flushCycles++;
            if (bus.o_redirect_v === 1'b1) begin
                rdCycles++;
                if (rdCycles == 1) begin
                    bus.i_fetch_redirect_ready = 1'b1;
                    ext_flush = 1'b1;
                end
            end
            if (c == 5) begin
                compared++;
                if (bus.o_redirect_v !== 1'b0 || busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL extf_redirect_abort: got rv %b busy %b expected 0 0",
                             bus.o_redirect_v, busy);
                end
                ext_flush = 1'b0;
                bus.i_fetch_redirect_ready = 1'b0;
                bus.i_rob_commit_req       = 1'b0;
                bus.i_brt_commit_done      = 1'b0;
                bus.i_brt_commit_miss_pre  = 1'b0;
            end
        end
        expMispred++;
        compared++;
        if (flushCycles != 2 || rdCycles != 1) begin
            mismatched++;
            $display("[TB] FAIL extf_second_seq: got flush %0d redirect %0d expected 2 1", flushCycles, rdCycles);
        end
        compared++;
        if (ackSeen !== 1'b0 || commitCnt !== CNTW'(expCommit)) begin
            mismatched++;
            $display("[TB] FAIL extf_no_ack: got ack %b cnt %0d expected 0 %0d", ackSeen, commitCnt, expCommit);
        end
        compared++;
        if (mispredCnt !== CNTW'(expMispred)) begin
            mismatched++;
            $display("[TB] FAIL extf_mispred_cnt: got %0d expected %0d", mispredCnt, expMispred);
        end
    endtask

    // Request held across two branches; address advances right after the ack.
    task automatic test_back_to_back();
        logic [ROBSIZE-1:0] seenAddr[$];
        int ackCycles[$];
        @(negedge clk);
        bus.i_rob_commit_req      = 1'b1;
        bus.i_rob_commit_rob_addr = 8'd3;
        bus.i_brt_commit_done     = 1'b1;
        bus.i_brt_commit_miss_pre = 1'b0;
        expAddrQ.push_back(8'd3);
        expAddrQ.push_back(8'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.o_brt_commit === 1'b1) seenAddr.push_back(bus.o_brt_commit_rob_addr);
            if (bus.o_rob_commit_ack === 1'b1) begin
                ackCycles.push_back(c);
                if (ackCycles.size() == 1) begin
                    bus.i_rob_commit_rob_addr = 8'd4;
                end else begin
                    bus.i_rob_commit_req  = 1'b0;
                    bus.i_brt_commit_done = 1'b0;
                end
            end
        end
        expCommit += 2;
        compared++;
        if (seenAddr.size() != 2 || seenAddr[0] !== 8'd3 || seenAddr[1] !== 8'd4) begin
            mismatched++;
            $display("[TB] FAIL b2b_brt_sequence: got %0d requests expected 2 (addr 3 then 4)", seenAddr.size());
        end
        compared++;
        if (ackCycles.size() != 2 || ackCycles[0] != 2 || ackCycles[1] != 5) begin
            mismatched++;
            $display("[TB] FAIL b2b_ack_cycles: got %0d acks expected 2 at cycles 2 and 5", ackCycles.size());
        end
        compared++;
        if (commitCnt !== CNTW'(expCommit)) begin
            mismatched++;
            $display("[TB] FAIL b2b_commit_cnt: got %0d expected %0d", commitCnt, expCommit);
        end
    endtask

    // Asynchronous reset in the middle of REDIRECT, then a clean commit.
    task automatic test_async_reset();
        int ackCycle = -1;
        @(negedge clk);
        bus.i_rob_commit_req        = 1'b1;
        bus.i_rob_commit_rob_addr   = 8'h33;
        bus.i_brt_commit_done       = 1'b1;
        bus.i_brt_commit_miss_pre   = 1'b1;
        bus.i_brt_commit_cal_target = 32'h0000_5000;
        bus.i_fetch_redirect_ready  = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (bus.o_redirect_v !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL arst_pre_redirect: got %b expected 1", bus.o_redirect_v);
        end
        #2;
        rstn = 1'b0;
        #1;
        compared++;
        if (bus.o_redirect_v !== 1'b0 || busy !== 1'b0 || flush !== 1'b0 || timeoutErr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL arst_flags: got rv %b busy %b flush %b err %b expected 0 0 0 0",
                     bus.o_redirect_v, busy, flush, timeoutErr);
        end
        compared++;
        if (commitCnt !== '0 || mispredCnt !== '0) begin
            mismatched++;
            $display("[TB] FAIL arst_counters: got %0d/%0d expected 0/0", commitCnt, mispredCnt);
        end
        expCommit  = 0;
        expMispred = 0;
        bus.i_rob_commit_req      = 1'b0;
        bus.i_brt_commit_done     = 1'b0;
        bus.i_brt_commit_miss_pre = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL arst_idle_after: got busy %b expected 0", busy);
        end
        bus.i_rob_commit_req      = 1'b1;
        bus.i_rob_commit_rob_addr = 8'd7;
        bus.i_brt_commit_done     = 1'b1;
        expAddrQ.push_back(8'd7);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.o_rob_commit_ack === 1'b1) begin
                if (ackCycle < 0) ackCycle = c;
                bus.i_rob_commit_req  = 1'b0;
                bus.i_brt_commit_done = 1'b0;
            end
        end
        expCommit++;
        compared++;
        if (ackCycle != 2 || commitCnt !== CNTW'(expCommit)) begin
            mismatched++;
            $display("[TB] FAIL arst_recommit: got ack cycle %0d cnt %0d expected 2 %0d",
                     ackCycle, commitCnt, expCommit);
        end
    endtask

    // Scenario sequence and final summary.
    initial begin
        test_reset();
        test_correct();
        test_mispredict();
        test_timeout();
        test_ext_flush();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        compared++;
        if (expAddrQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expAddrQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/brt_commit_ctrl.md
Name: brt_commit_ctrl

Overview:
- Sequences retirement of branch entries out of the branch resolution table (BRT).
- Accepts a commit request from the ROB head and drives the BRT commit handshake.
- On a correct prediction, acknowledges the ROB.
- On a misprediction, broadcasts a pipeline/BRT flush for a fixed number of cycles, then holds a fetch redirect until fetch accepts it, and only then acknowledges the ROB.

Parameters:
- ROBSIZE, 8: width of ROB address fields.
- FLUSH_CYCLES, 2: cycles o_flush is held per misprediction; must be >= 1.
- TIMEOUT, 64: REQ-state wait cycles before o_timeout_err sets; 0 disables the timeout.
- CNTW, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_ext_flush  in  1  external abort (exception/trap); returns the FSM to IDLE.
- i_rob_commit_req  in  1  ROB head is a branch ready to retire; held until ack.
- i_rob_commit_rob_addr  in  ROBSIZE  ROB address of that branch.
- o_rob_commit_ack  out  1  one-cycle pulse: branch retired.
- o_brt_commit  out  1  commit request to BRT.
- o_brt_commit_rob_addr  out  ROBSIZE  latched ROB address sent to BRT.
- i_brt_commit_done  in  1  BRT entry resolved and released (combinational from BRT).
- i_brt_commit_miss_pre  in  1  valid with done: mispredicted.
- i_brt_commit_cal_target  in  32  valid with done: correct next PC.
- o_flush  out  1  flush to BRT, ROB and pipeline.
- o_redirect_v  out  1  fetch redirect valid.
- o_redirect_pc  out  32  redirect PC.
- i_fetch_redirect_ready  in  1  fetch accepts redirect.
- o_busy  out  1  FSM not in IDLE.
- o_timeout_err  out  1  sticky: BRT failed to resolve within TIMEOUT.
- o_commit_cnt  out  CNTW  retired branches (wraps).
- o_mispred_cnt  out  CNTW  mispredictions (wraps).

Behaviour:
- Reset: rstn low asynchronously forces IDLE and clears all registers. Every output resets to 0.
- Outputs: all are driven from registered state, with none combinational from inputs.
- States: IDLE, REQ, FLUSH, REDIRECT, ACK.
- IDLE:
  - If i_rob_commit_req=1, latch i_rob_commit_rob_addr into o_brt_commit_rob_addr and go to REQ.
  - Otherwise stay.
- REQ:
  - o_brt_commit=1.
  - On a clock edge with i_brt_commit_done=1, latch miss_pre and cal_target.
  - If miss_pre=0, go to ACK.
  - If miss_pre=1, go to FLUSH and increment o_mispred_cnt.
  - While done=0, a wait counter increments (saturating). When it reaches TIMEOUT (TIMEOUT>0), set o_timeout_err and keep waiting. The wait counter clears on leaving REQ.
- FLUSH:
  - o_flush=1 for exactly FLUSH_CYCLES consecutive cycles, then go to REDIRECT.
  - o_redirect_pc is already valid during FLUSH.
- REDIRECT:
  - o_redirect_v=1 and o_redirect_pc=latched target, both held stable.
  - On an edge with i_fetch_redirect_ready=1, go to ACK. Ready in the first REDIRECT cycle is legal.
- ACK: o_rob_commit_ack=1 for one cycle, increment o_commit_cnt, go to IDLE.
- ROB handshake:
  - The ROB must drop or advance i_rob_commit_req in the cycle after the ack.
  - i_rob_commit_req is ignored in every state except IDLE.
- Latency, correct prediction: req sampled at edge 0 → REQ in cycle 1 (done same cycle) → ACK in cycle 2 → IDLE in cycle 3. Minimum 2 cycles from req to ack.
- Latency, misprediction: 2 + FLUSH_CYCLES + (redirect wait) + 1 cycles minimum.
- i_ext_flush:
  - In any state it forces IDLE at the next edge with no ack and no counter increments, and clears the wait and flush counters. It does not clear o_timeout_err or the perf counters.
  - It has priority over i_brt_commit_done and i_fetch_redirect_ready in the same cycle.
- Counters: both wrap at 2^CNTW, and increment at most once per cycle.
- Reset mid-operation: any state returns to IDLE immediately; o_flush and o_redirect_v drop asynchronously.

Test Plan:
- Reset, then req addr=5 with BRT done=1, miss=0 in the first REQ cycle → o_brt_commit high 1 cycle with addr=5; ack pulse exactly 2 cycles after req edge; o_commit_cnt=1; o_flush never high.
- Req addr=9, done=1, miss=1, target=0x0000_1000, FLUSH_CYCLES=2, fetch ready 3 cycles after REDIRECT entry → o_flush high 2 cycles; o_redirect_v high 3 cycles with pc=0x1000; ack next; o_mispred_cnt=1, o_commit_cnt=1.
- Req with done held 0 for 70 cycles (TIMEOUT=64) → o_timeout_err rises after 64 REQ cycles and stays set; then done=1, miss=0 → normal ack; err remains 1 until reset.
- i_ext_flush asserted in FLUSH cycle 1 and, separately, in REDIRECT coincident with ready=1 → FSM returns to IDLE next edge, no ack, o_commit_cnt unchanged, o_redirect_v low.
- Back-to-back req held continuously for addrs 3 then 4 → two REQ/ACK sequences, 3 cycles apart, with no request skipped or duplicated.
- rstn pulled low asynchronously mid-REDIRECT → o_redirect_v, o_busy and counters go 0 immediately; FSM is in IDLE after release.
